// File: rtl/flopr_pkg.sv
// flopr_pkg: shared defaults and occupancy-width helper for flopr_pipe
package flopr_pkg;
  localparam int N_DEF = 32;
  localparam int DEPTH_DEF = 2;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/flopr_pipe_stage.sv
// flopr_pipe_stage: one valid bit plus data register with ready chaining
module flopr_pipe_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         v_in,
  input  logic [N-1:0] d_in,
  input  logic         rdy_nxt,
  output logic         rdy,
  output logic         v_q,
  output logic [N-1:0] r_q
);
  logic         v_d;
  logic [N-1:0] r_d;
  always_comb begin
    rdy = !v_q || rdy_nxt;
    v_d = flush ? 1'b0 : (rdy ? v_in : v_q);
    r_d = (!flush && rdy && v_in) ? d_in : r_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end
endmodule

// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage valid/ready register pipeline with flush;
// define FLOPR_PIPE_OCC_EN to add the registered occupancy output occ.
module flopr_pipe
  import flopr_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              d,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef FLOPR_PIPE_OCC_EN
  output logic [occ_w(DEPTH)-1:0]   occ,
`endif
  output logic [N-1:0]              q
);
  logic [DEPTH:0]        v;
  logic [DEPTH:0][N-1:0] r;
  assign v[0] = in_valid;
  assign r[0] = d;
  // ready lives per generate scope so the backward chain is not one self-dependent vector
  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    logic rdy;
    logic rdy_nxt;
    if (g == DEPTH - 1) begin : g_last
      assign rdy_nxt = out_ready;
    end else begin : g_mid
      assign rdy_nxt = g_stg[g+1].rdy;
    end
    flopr_pipe_stage #(.N(N)) u_stage (
      .clk(clk), .rst(rst), .flush(flush),
      .v_in(v[g]), .d_in(r[g]), .rdy_nxt(rdy_nxt),
      .rdy(rdy), .v_q(v[g+1]), .r_q(r[g+1])
    );
  end
  assign in_ready  = g_stg[0].rdy && !flush;
  assign out_valid = v[DEPTH] && !flush;
  assign q         = r[DEPTH];
`ifdef FLOPR_PIPE_OCC_EN
  localparam int OW = occ_w(DEPTH);
  logic [OW-1:0] occ_q, occ_d;
  always_comb begin
    occ_d = flush ? '0 : occ_q + OW'(in_valid && in_ready) - OW'(out_valid && out_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign occ = occ_q;
`endif
endmodule
